hilo_muldiv_unit: RTL and testbench

Iterative multiply/divide unit that owns the HI/LO architectural registers of the datapath.
- Hi and Lo feed the mfhi/mflo inputs of the 32-bit 5:1 result-select mux in the execute stage.
- Implements MULT, MULTU, DIV, DIVU, MADD and MSUB as multi-cycle operations, plus single-cycle MTHI and MTLO.
- Hazard logic stalls the pipeline on Busy.

---
 rtl/hilo_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner with an iterative multiply/divide engine.
// MULT/MULTU/DIV/DIVU/MADD/MSUB take DATA_W+1 edges; MTHI/MTLO write in one edge.
module hilo_muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;
  logic              dbz_q, dbz_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic                signed_in, div_in, div_run, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum, div_shift, div_sub;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod, sprod;

  always_comb begin
    signed_in = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    div_in    = (Op == OP_DIV) || (Op == OP_DIVU);
    a_neg     = signed_in & A[DATA_W-1];
    b_neg     = signed_in & B[DATA_W-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;

    div_run   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    div_sub   = div_shift - {1'b0, mcand_q};

    prod      = {acc_hi_q, acc_lo_q};
    sprod     = neg_q ? -prod : prod;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    dbz_d    = dbz_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end else begin
            // Multiply: acc_lo holds the multiplier; divide: acc_lo holds the dividend.
            op_d     = Op;
            neg_d    = a_neg ^ b_neg;
            negr_d   = a_neg;
            dbz_d    = (B == '0);
            mcand_d  = div_in ? b_mag : a_mag;
            acc_lo_d = div_in ? a_mag : b_mag;
            acc_hi_d = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (div_run) begin
          acc_hi_d = div_ge ? div_sub[DATA_W-1:0] : div_shift[DATA_W-1:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[DATA_W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        case (op_q)
          OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + sprod;
          OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - sprod;
          OP_DIV, OP_DIVU: begin
            // Remainder already equals |A| on divide-by-zero, so only the quotient is forced.
            lo_d = dbz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
            hi_d = negr_q ? -acc_hi_q : acc_hi_q;
          end
          default: {hi_d, lo_d} = sprod;
        endcase
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dbz_q    <= 1'b0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      dbz_q    <= dbz_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected {Hi,Lo} pairs come from a
// behavioural model and are queued at issue, then popped when Done fires.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  logic [63:0] shadow;
  logic [63:0] sb_q[$];

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd6: return hl + 64'(sa * sb);
      3'd7: return hl - 64'(sa * sb);
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return hl;
    endcase
  endfunction

  // Issues one multi-cycle op and waits (bounded) for Done; lat counts edges after the Start edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] got, output int lat);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!Done && lat < 100);
    got = {Hi, Lo};
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] got;
    int lat;
    bit saw_done;
    Rst = 1'b0; Start = 1'b1; Op = 3'd4; A = 32'hFFFF_0000; B = '0;
    repeat (2) @(posedge Clk);
    #1;
    tests_run++;
    if ({Hi, Lo, Busy, Done} !== 66'h0) begin
      tests_failed++;
      $display("FAIL reset_state: Hi=%h Lo=%h Busy=%b Done=%b, want all zero", Hi, Lo, Busy, Done);
    end
    Start = 1'b0;
    Rst = 1'b1;
    do_mt(3'd4, 32'h55);
    do_mt(3'd5, 32'h66);
    // MULT, then reset for one edge while it runs
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'd9; B = 32'd9;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk); Rst = 1'b0;
    @(posedge Clk); #1; Rst = 1'b1;
    tests_run++;
    if ({Hi, Lo, Busy, Done} !== 66'h0) begin
      tests_failed++;
      $display("FAIL reset_midrun: Hi=%h Lo=%h Busy=%b Done=%b, want all zero", Hi, Lo, Busy, Done);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done || Busy) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: Done/Busy seen after abort, want none");
    end
    shadow = '0;
    got = '0; lat = 0;
  endtask

  task automatic test_mult;
    logic [63:0] got, exp;
    int lat;
    sb_q.push_back(model(3'd0, 32'd7, 32'hFFFFFFFD, shadow));
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, got, lat);
    exp = sb_q.pop_front(); shadow = exp;
    tests_run++;
    if (got !== exp || exp !== 64'hFFFFFFFF_FFFFFFEB) begin
      tests_failed++;
      $display("FAIL mult_signed: got %h want %h", got, exp);
    end
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL mult_latency: got %0d want 33", lat);
    end
    @(posedge Clk); #1;
    tests_run++;
    if (Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse: Done=%b one cycle later, want 0", Done);
    end
    sb_q.push_back(model(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, shadow));
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, got, lat);
    exp = sb_q.pop_front(); shadow = exp;
    tests_run++;
    if (got !== exp || exp !== 64'hFFFFFFFE_00000001) begin
      tests_failed++;
      $display("FAIL multu: got %h want %h", got, exp);
    end
  endtask

  task automatic test_div;
    logic [63:0] got, exp;
    int lat;
    logic [2:0]  ops [4] = '{3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'd100, 32'h1234, 32'h80000000};
    logic [31:0] bs  [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF};
    logic [63:0] ref_v [4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E,
                               64'h00001234_FFFFFFFF, 64'h00000000_80000000};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(model(ops[i], as[i], bs[i], shadow));
      run_op(ops[i], as[i], bs[i], got, lat);
      exp = sb_q.pop_front(); shadow = exp;
      tests_run++;
      if (got !== exp || exp !== ref_v[i] || lat !== 33) begin
        tests_failed++;
        $display("FAIL div_%0d: got %h lat %0d want %h lat 33", i, got, lat, ref_v[i]);
      end
    end
  endtask

  task automatic test_madd;
    logic [63:0] got, exp;
    int lat;
    do_mt(3'd4, 32'h0);
    tests_run++;
    if (Hi !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mthi: Hi=%h Busy=%b Done=%b want 0/0/0", Hi, Busy, Done);
    end
    do_mt(3'd5, 32'h10);
    tests_run++;
    if (Lo !== 32'h10 || Busy !== 1'b0 || Done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo: Lo=%h Busy=%b Done=%b want 10/0/0", Lo, Busy, Done);
    end
    shadow = 64'h10;
    sb_q.push_back(model(3'd6, 32'd3, 32'd4, shadow));
    run_op(3'd6, 32'd3, 32'd4, got, lat);
    exp = sb_q.pop_front(); shadow = exp;
    tests_run++;
    if (got !== exp || exp !== 64'h1C) begin
      tests_failed++;
      $display("FAIL madd: got %h want %h", got, exp);
    end
    sb_q.push_back(model(3'd7, 32'd5, 32'd6, shadow));
    run_op(3'd7, 32'd5, 32'd6, got, lat);
    exp = sb_q.pop_front(); shadow = exp;
    tests_run++;
    if (got !== exp || exp !== 64'hFFFFFFFF_FFFFFFFE) begin
      tests_failed++;
      $display("FAIL msub: got %h want %h", got, exp);
    end
  endtask

  task automatic test_ignore;
    logic [63:0] exp;
    int lat;
    bit held_ok;
    sb_q.push_back(model(3'd0, 32'h1111, 32'h2222, shadow));
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'h1111; B = 32'h2222;
    @(posedge Clk); #1;
    held_ok = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (i == 5) begin
        Start = 1'b1; Op = 3'd5; A = 32'hDEAD;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
      lat = i;
      if (Done) break;
      if (Busy !== 1'b1 || {Hi, Lo} !== shadow) held_ok = 1'b0;
    end
    Start = 1'b0;
    tests_run++;
    if (held_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_during_run: Hi/Lo or Busy changed before commit");
    end
    exp = sb_q.pop_front(); shadow = exp;
    tests_run++;
    if ({Hi, Lo} !== exp || lat !== 33) begin
      tests_failed++;
      $display("FAIL start_ignored: got %h lat %0d want %h lat 33", {Hi, Lo}, lat, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] got, exp;
    int lat;
    sb_q.push_back(model(3'd3, 32'd1000, 32'd33, shadow));
    run_op(3'd3, 32'd1000, 32'd33, got, lat);
    exp = sb_q.pop_front(); shadow = exp;
    tests_run++;
    if (got !== exp || lat !== 33) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h lat %0d want %h lat 33", got, lat, exp);
    end
    sb_q.push_back(model(3'd6, 32'hFFFFFFF0, 32'd16, shadow));
    run_op(3'd6, 32'hFFFFFFF0, 32'd16, got, lat);
    exp = sb_q.pop_front(); shadow = exp;
    tests_run++;
    if (got !== exp || lat !== 33) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h lat %0d want %h lat 33", got, lat, exp);
    end
  endtask

  task automatic test_random;
    logic [63:0] got, exp;
    int lat;
    logic [2:0]  op_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = op_tab[$urandom_range(0, 5)];
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      sb_q.push_back(model(op, a, b, shadow));
      run_op(op, a, b, got, lat);
      exp = sb_q.pop_front(); shadow = exp;
      tests_run++;
      if (got !== exp || lat !== 33) begin
        tests_failed++;
        $display("FAIL rand_%0d op%0d a=%h b=%h: got %h lat %0d want %h", i, op, a, b, got, lat, exp);
      end
    end
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
    shadow = '0;
    test_reset();
    test_mult();
    test_div();
    test_madd();
    test_ignore();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
